// File: rtl/percep_pkg.sv
// Shared constants and state encoding for the perceptron yd/x sample sequencer.
package percep_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_VALID = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int unsigned YD_BIT          = 16;
    localparam int unsigned X_MSB           = 15;
    localparam int unsigned ATTR            = 5;
    localparam int unsigned NUM_SAMPLES_DEF = 100;

endpackage

// File: rtl/percep_ydx_seq.sv
// Owns the yd/x sample memory: host preload while idle, then streams rows over valid/ready.
// Optional multi-epoch replay is enabled by defining PERCEP_YDX_SEQ_EPOCH_EN.
module percep_ydx_seq
    import percep_pkg::*;
#(
    parameter int unsigned MEM_WIDTH   = 17,
    parameter int unsigned MEM_ADDR    = 7,
    parameter int unsigned NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int unsigned EPOCH_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [EPOCH_W-1:0]   cfg_epochs,
    input  logic                 load_we,
    input  logic [MEM_ADDR-1:0]  load_addr,
    input  logic [MEM_WIDTH-1:0] load_data,
    output logic                 load_err,
    output logic                 samp_valid,
    input  logic                 samp_ready,
    output logic [15:0]          samp_x,
    output logic                 samp_yd,
    output logic [MEM_ADDR-1:0]  samp_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic                 mem_oe,
    output logic [MEM_ADDR-1:0]  mem_addr,
    output logic [MEM_WIDTH-1:0] mem_din,
    input  logic [MEM_WIDTH-1:0] mem_dout
);

    localparam logic [MEM_ADDR-1:0] LAST = MEM_ADDR'(NUM_SAMPLES - 1);

    state_t              state_q, state_d;
    logic [MEM_ADDR-1:0] ptr_q, ptr_d, idx_q, idx_d;
    logic [X_MSB:0]      x_q, x_d;
    logic                yd_q, yd_d;

    logic                streaming, more, hs, go, pass_end, last_pass;
    logic [MEM_ADDR-1:0] ptr_nxt;

    assign streaming = (state_q == ST_FETCH) || (state_q == ST_VALID);
    assign more      = (ptr_q != LAST);
    assign ptr_nxt   = ptr_q + MEM_ADDR'(1);
    assign hs        = (state_q == ST_VALID) && samp_ready;
    assign pass_end  = hs && !more;
    // A write on the same cycle as start wins; start is dropped.
    assign go        = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !load_we;

`ifdef PERCEP_YDX_SEQ_EPOCH_EN
    logic [EPOCH_W-1:0] ep_q, ep_d;

    assign last_pass = (ep_q <= EPOCH_W'(1));

    always_comb begin
        ep_d = ep_q;
        if (go) begin
            ep_d = (cfg_epochs == '0) ? EPOCH_W'(1) : cfg_epochs;
        end else if (pass_end && !last_pass) begin
            ep_d = ep_q - EPOCH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ep_q <= '0;
        else        ep_q <= ep_d;
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^cfg_epochs;
    assign last_pass  = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        x_d     = x_q;
        yd_d    = yd_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_we) begin
                    state_d = ST_IDLE;
                end else if (go) begin
                    ptr_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                x_d     = mem_dout[X_MSB:0];
                yd_d    = mem_dout[YD_BIT];
                idx_d   = ptr_q;
                state_d = ST_VALID;
            end
            default: begin
                if (hs && more) begin
                    // Row ptr+1 was prefetched this cycle, so the next sample is ready now.
                    x_d   = mem_dout[X_MSB:0];
                    yd_d  = mem_dout[YD_BIT];
                    idx_d = ptr_nxt;
                    ptr_d = ptr_nxt;
                end else if (pass_end) begin
                    if (last_pass) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
            end
        endcase
    end

    always_comb begin
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_oe   = 1'b0;
        mem_addr = load_addr;
        mem_din  = load_data;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                mem_cs = load_we;
                mem_we = load_we;
            end
            ST_FETCH: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_addr = ptr_q;
            end
            default: begin
                mem_cs   = more;
                mem_oe   = more;
                mem_addr = ptr_nxt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            yd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            yd_q    <= yd_d;
        end
    end

    assign samp_valid = (state_q == ST_VALID);
    assign samp_x     = x_q;
    assign samp_yd    = yd_q;
    assign samp_idx   = idx_q;
    assign busy       = streaming;
    assign done       = (state_q == ST_DONE);
    assign load_err   = load_we && streaming;

endmodule

// File: tb/tb_percep_ydx_seq.sv
// Directed bench for percep_ydx_seq with a behavioural sample memory alongside the DUT.
module tb_percep_ydx_seq;

    localparam int NS = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_epochs = 8'd1;
    logic        load_we = 1'b0;
    logic [6:0]  load_addr = '0;
    logic [16:0] load_data = '0;
    logic        load_err, samp_valid, samp_yd, busy, done;
    logic        samp_ready = 1'b0;
    logic [15:0] samp_x;
    logic [6:0]  samp_idx;
    logic        mem_cs, mem_we, mem_oe;
    logic [6:0]  mem_addr;
    logic [16:0] mem_din, mem_dout;

    logic [16:0] mem [0:127];
    logic [16:0] exp_row [0:127];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mem_dout = (mem_cs && mem_oe) ? mem[mem_addr] : 17'h0;
    always @(posedge clk) if (mem_cs && mem_we) mem[mem_addr] <= mem_din;

    percep_ydx_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_epochs (cfg_epochs),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_err   (load_err),
        .samp_valid (samp_valid),
        .samp_ready (samp_ready),
        .samp_x     (samp_x),
        .samp_yd    (samp_yd),
        .samp_idx   (samp_idx),
        .busy       (busy),
        .done       (done),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_oe     (mem_oe),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    task automatic do_write(input logic [6:0] a, input logic [16:0] d);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        exp_row[a] = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || samp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency: busy=%b valid=%b, want busy=1 valid=0", busy, samp_valid);
        end
    endtask

    // Consumes n_hs handshakes; the first presented row is first_idx.
    task automatic run_stream(input int n_hs, input bit rnd, input int first_idx,
                              input int exp_cyc, input string tag);
        int hs = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [15:0] px = '0;
        logic        py = 1'b0;
        logic [6:0]  pi = '0;
        int e;
        while (hs < n_hs && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                n_checks++;
                if (samp_x !== px || samp_yd !== py || samp_idx !== pi) begin
                    n_fail++;
                    $display("FAIL %s stall_stable: got idx=%0d x=%h yd=%b want idx=%0d x=%h yd=%b",
                             tag, samp_idx, samp_x, samp_yd, pi, px, py);
                end
            end
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early_done: done=%b after %0d handshakes, want 0", tag, done, hs);
            end
            n_checks++;
            if (mem_cs && mem_oe && mem_addr > 7'(NS - 1)) begin
                n_fail++;
                $display("FAIL %s addr_range: mem_addr=%0d, want <= %0d", tag, mem_addr, NS - 1);
            end
            samp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (samp_valid) begin
                e = (first_idx + hs) % NS;
                n_checks++;
                if (samp_idx !== 7'(e) || {samp_yd, samp_x} !== exp_row[e]) begin
                    n_fail++;
                    $display("FAIL %s sample: got idx=%0d data=%h want idx=%0d data=%h",
                             tag, samp_idx, {samp_yd, samp_x}, e, exp_row[e]);
                end
                if (samp_ready) hs++;
                stalled = !samp_ready;
                px = samp_x;
                py = samp_yd;
                pi = samp_idx;
            end else begin
                stalled = 1'b0;
            end
        end
        n_checks++;
        if (hs != n_hs) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d handshakes, want %0d", tag, hs, n_hs);
        end
        if (exp_cyc >= 0) begin
            n_checks++;
            if (cyc != exp_cyc) begin
                n_fail++;
                $display("FAIL %s cycles: got %0d, want %0d", tag, cyc, exp_cyc);
            end
        end
        @(negedge clk);
        samp_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || samp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: done=%b busy=%b valid=%b, want 1 0 0", tag, done, busy, samp_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({samp_valid, busy, done, load_err, mem_cs, mem_we, mem_oe} !== 7'b0 ||
            samp_x !== 16'h0 || samp_yd !== 1'b0 || samp_idx !== 7'h0) begin
            n_fail++;
            $display("FAIL reset: v=%b b=%b d=%b e=%b cs=%b x=%h yd=%b idx=%0d, want all 0",
                     samp_valid, busy, done, load_err, mem_cs, samp_x, samp_yd, samp_idx);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_preload();
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = 7'd9;
        load_data = 17'h1FFFF;
        #1;
        n_checks++;
        if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_addr !== 7'd9 ||
            mem_din !== 17'h1FFFF || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL preload_port: cs=%b we=%b oe=%b addr=%0d din=%h err=%b, want 1 1 0 9 1ffff 0",
                     mem_cs, mem_we, mem_oe, mem_addr, mem_din, load_err);
        end
        for (int i = 0; i < 128; i++) begin
            logic [16:0] r;
            r = (i < NS) ? {i[0], 16'(i * 3)} : 17'h1FFFF;
            do_write(7'(i), r);
        end
    endtask

    task automatic test_stream();
        samp_ready = 1'b1;
        do_start();
        run_stream(NS, 1'b0, 0, NS, "stream");
    endtask

    task automatic test_random_stalls();
        samp_ready = 1'b0;
        do_start();
        run_stream(NS, 1'b1, 0, -1, "stalls");
    endtask

    task automatic test_load_err();
        int guard = 0;
        samp_ready = 1'b1;
        do_start();
        while (!(samp_valid && samp_idx == 7'd5) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        samp_ready = 1'b0;
        load_we    = 1'b1;
        load_addr  = 7'd5;
        load_data  = 17'h0ABCD;
        #1;
        n_checks++;
        if (load_err !== 1'b1 || mem_we !== 1'b0 || samp_idx !== 7'd5) begin
            n_fail++;
            $display("FAIL load_err_pulse: err=%b we=%b idx=%0d, want 1 0 5", load_err, mem_we, samp_idx);
        end
        @(negedge clk);
        load_we = 1'b0;
        #1;
        n_checks++;
        if (load_err !== 1'b0 || samp_valid !== 1'b1 || samp_idx !== 7'd5) begin
            n_fail++;
            $display("FAIL load_err_end: err=%b valid=%b idx=%0d, want 0 1 5", load_err, samp_valid, samp_idx);
        end
        run_stream(NS - 5, 1'b0, 5, -1, "load_err_rest");
        samp_ready = 1'b1;
        do_start();
        run_stream(NS, 1'b0, 0, NS, "load_err_restream");
    endtask

    task automatic test_start_write();
        do_write(7'd8, exp_row[8]);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_clears_done: done=%b busy=%b, want 0 0", done, busy);
        end
        @(negedge clk);
        start     = 1'b1;
        load_we   = 1'b1;
        load_addr = 7'd7;
        load_data = 17'h15555;
        exp_row[7] = 17'h15555;
        @(negedge clk);
        start   = 1'b0;
        load_we = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || samp_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_write: busy=%b valid=%b done=%b, want 0 0 0", busy, samp_valid, done);
        end
        samp_ready = 1'b1;
        do_start();
        run_stream(NS, 1'b0, 0, NS, "new_data");
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        samp_ready = 1'b1;
        do_start();
        while (!(samp_valid && samp_idx == 7'd40) && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({samp_valid, busy, done, load_err, mem_cs} !== 5'b0 || samp_x !== 16'h0 ||
            samp_yd !== 1'b0 || samp_idx !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_mid: v=%b b=%b d=%b cs=%b x=%h yd=%b idx=%0d, want all 0",
                     samp_valid, busy, done, mem_cs, samp_x, samp_yd, samp_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        run_stream(NS, 1'b0, 0, NS, "after_reset");
    endtask

    task automatic test_epochs();
        samp_ready = 1'b1;
        cfg_epochs = 8'd3;
        do_start();
        cfg_epochs = 8'd1;
`ifdef PERCEP_YDX_SEQ_EPOCH_EN
        run_stream(3 * NS, 1'b0, 0, 3 * NS + 2, "epochs3");
        cfg_epochs = 8'd0;
        do_start();
        cfg_epochs = 8'd1;
        run_stream(NS, 1'b0, 0, NS, "epochs0");
`else
        run_stream(NS, 1'b0, 0, NS, "epochs_ignored");
`endif
    endtask

    initial begin
        test_reset();
        test_preload();
        test_stream();
        test_random_stalls();
        test_load_err();
        test_start_write();
        test_reset_mid();
        test_epochs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
